// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-stage hazard bus between the pipeline front end and the forwarding/hazard scoreboard.
// The pipeline side is the master; the scoreboard is the slave.
interface fwd_hazard_scoreboard_if #(
    parameter int NUM_READ_PORTS = 2,
    parameter int DEPTH          = 3
);
    localparam int SEL_W = $clog2(DEPTH);

    logic                            id_valid;
    logic [4:0]                      id_rd_idx;
    logic                            id_rd_wr_en;
    logic                            id_is_load;
    logic [5*NUM_READ_PORTS-1:0]     id_rs_idx;
    logic                            flush;
    logic                            stall;
    logic [SEL_W*NUM_READ_PORTS-1:0] ex_fwd_sel;

    modport master (
        output id_valid, id_rd_idx, id_rd_wr_en, id_is_load, id_rs_idx, flush,
        input  stall, ex_fwd_sel
    );

    modport slave (
        input  id_valid, id_rd_idx, id_rd_wr_en, id_is_load, id_rs_idx, flush,
        output stall, ex_fwd_sel
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Shadow tag pipeline (EX..WB) producing registered EX forwarding selects and the load-use stall.
// Optional FWD_HAZARD_STATS_EN adds saturating stall/forward event counters.
module fwd_hazard_scoreboard #(
    parameter  int NUM_READ_PORTS = 2,
    parameter  int DEPTH          = 3,
    parameter  int LOAD_FWD_MIN   = 2,
    localparam int SEL_W          = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    fwd_hazard_scoreboard_if.slave bus
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]           stat_stall_cnt,
    output logic [31:0]           stat_fwd_cnt
`endif
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
    } tag_t;

    tag_t                                    tags [DEPTH];
    logic [DEPTH-2:0]                        live;
    logic [NUM_READ_PORTS-1:0][SEL_W-1:0]    cand_sel;
    logic [NUM_READ_PORTS-1:0]               cand_haz;
    logic [NUM_READ_PORTS-1:0][SEL_W-1:0]    fwd_q;
    logic                                    stall_c;

    // The WB entry is never searched: the regfile write lands before the ID read.
    always_comb begin
        for (int e = 0; e < DEPTH - 1; e++) begin
            live[e] = tags[e].valid && tags[e].wr_en && (tags[e].rd != 5'd0);
        end
    end

    // Scan oldest to youngest so the youngest matching producer is the last write.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
        cand_sel = '0;
        cand_haz = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            for (int e = DEPTH - 2; e >= 0; e--) begin
                if (live[e] && (bus.id_rs_idx[5*p +: 5] != 5'd0) &&
                    (tags[e].rd == bus.id_rs_idx[5*p +: 5])) begin
                    cand_sel[p] = SEL_W'(e + 1);
                    cand_haz[p] = tags[e].is_load && ((e + 1) < LOAD_FWD_MIN);
                end
            end
        end
    end

    assign stall_c        = bus.id_valid && !bus.flush && (|cand_haz);
    assign bus.stall      = stall_c;
    assign bus.ex_fwd_sel = fwd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag array is tiny and its valid bits gate every decision, so all of it is reset.
            for (int e = 0; e < DEPTH; e++) begin
                tags[e] <= '0;
            end
            fwd_q <= '0;
        end else begin
            // NOTE: non-blocking so each entry takes the previous cycle's value of its neighbour.
            for (int e = 1; e < DEPTH; e++) begin
                tags[e] <= tags[e-1];
            end
            if (bus.flush || stall_c) begin
                tags[0] <= '0;
                fwd_q   <= '0;
            end else begin
                tags[0] <= '{valid: bus.id_valid, rd: bus.id_rd_idx,
                             wr_en: bus.id_rd_wr_en, is_load: bus.id_is_load};
                fwd_q   <= bus.id_valid ? cand_sel : '0;
            end
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic fwd_event;
    assign fwd_event = bus.id_valid && !bus.flush && !stall_c && (|cand_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            if (stall_c && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
            if (fwd_event && (stat_fwd_cnt != 32'hFFFF_FFFF)) begin
                stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
